keygen_unloader: RTL



---
 rtl/keygen_unloader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/keygen_unloader.sv
// keygen_unloader
//
// Drains keygen's output RAM after a key generation completes. Bytes are
// read through the one-cycle-latency output_addr/output_do port. They are
// packed little-endian into 32-bit words and streamed out on m_data with
// full backpressure.
//
// Handshake: a word transfers on a rising clk edge where m_valid and m_ready
// are both high. Once m_valid is raised, m_data and m_last hold until that
// transfer happens. m_valid never depends combinationally on m_ready.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start             begin a drain (ignored unless idle)
//   busy              high while a drain is in progress
//   done              one-cycle pulse after the m_last word is accepted
//   output_addr       byte address to keygen's output RAM
//   output_do         RAM read data, valid one cycle after the address
//   m_data/m_valid/m_last/m_ready   word stream to the host
//   state_dbg         current FSM state, for observation only
module keygen_unloader #(
    parameter int N_BYTES = 1824,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] output_addr,
    input  logic [7:0]        output_do,
    output logic [31:0]       m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [1:0]        state_dbg
);

    localparam int N_WORDS = N_BYTES / 4;
    localparam int WC_W    = $clog2(N_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   done_nxt;

    logic [ADDR_W-1:0] rd_ptr;
    logic [1:0]        rd_lane;   // packer lane for the next captured byte
    logic              rd_pend;   // a read was issued last cycle; capture now
    logic [WC_W-1:0]   word_cnt;
    logic [7:0]        pk0, pk1, pk2;

    // 2-entry output FIFO, each entry {last, word}
    logic [32:0] fifo_mem [2];
    logic        fifo_wp, fifo_rp;
    logic [1:0]  fifo_cnt;

    logic [2:0]  committed;
    logic        credit_ok, issue, last_issue, push, pop, push_last;
    logic [31:0] push_word;
    logic [32:0] head;

    // Reservation check: words already queued plus the word that the packer
    // is about to complete. rd_lane==3 means three bytes are held, so the
    // next captured byte (in flight or still to be issued) pushes a word.
    // Allowing a read only when that total is at most 1 guarantees a free
    // FIFO slot at every lane-3 capture.
    always_comb begin
        committed  = {1'b0, fifo_cnt} + {2'b00, (rd_lane == 2'd3)};
        credit_ok  = (committed <= 3'd1);
        issue      = (state == RUN) && credit_ok;
        last_issue = issue && (rd_ptr == ADDR_W'(N_BYTES - 1));
        push       = rd_pend && (rd_lane == 2'd3);
        pop        = m_valid && m_ready;
        push_word  = {output_do, pk2, pk1, pk0};
        push_last  = (word_cnt == WC_W'(N_WORDS - 1));
        head       = fifo_mem[fifo_rp];
    end

    assign m_valid     = (fifo_cnt != 2'd0);
    assign m_data      = head[31:0];
    assign m_last      = m_valid && head[32];
    assign output_addr = issue ? rd_ptr : '0;
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state and done request
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (last_issue) state_nxt = FLUSH;
            end
            FLUSH: begin
                // The m_last word is the final push, so its transfer also
                // leaves the FIFO empty.
                if (pop && m_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read pointer, packer and FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 1'b0;
            rd_ptr      <= '0;
            rd_lane     <= 2'd0;
            rd_pend     <= 1'b0;
            word_cnt    <= '0;
            pk0         <= 8'h00;
            pk1         <= 8'h00;
            pk2         <= 8'h00;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            done <= done_nxt;
            if (state == IDLE) begin
                if (start) begin
                    rd_ptr   <= '0;
                    rd_lane  <= 2'd0;
                    rd_pend  <= 1'b0;
                    word_cnt <= '0;
                    fifo_wp  <= 1'b0;
                    fifo_rp  <= 1'b0;
                    fifo_cnt <= 2'd0;
                end
            end else begin
                rd_pend <= issue;
                if (issue) rd_ptr <= rd_ptr + 1'b1;

                if (rd_pend) begin
                    case (rd_lane)
                        2'd0:    pk0 <= output_do;
                        2'd1:    pk1 <= output_do;
                        2'd2:    pk2 <= output_do;
                        default: ;  // lane 3 goes straight into the FIFO
                    endcase
                    rd_lane <= rd_lane + 2'd1;
                end

                if (push) begin
                    fifo_mem[fifo_wp] <= {push_last, push_word};
                    fifo_wp           <= ~fifo_wp;
                    word_cnt          <= word_cnt + 1'b1;
                end
                if (pop) fifo_rp <= ~fifo_rp;

                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                    2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end

endmodule
